// File: rtl/irq_sequencer.sv
// Interrupt entry sequencer: synchronizes irq_in and holds the request pending
// until the I flag allows entry. It then drains the pipeline, issues INT to the
// decoder, forces one vector fetch and blocks re-entry until RETIE executes.
module irq_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [9:0]  VECTOR_ADDR  = 10'h3FF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irq_in,
  input  logic       i_flag,
  input  logic       redirect_ex,
  input  logic       hazard_stall,
  input  logic [9:0] fetch_addr,
  input  logic       reti_ex,
  output logic       fetch_hold,
  output logic       dec_nop,
  output logic       int_dec,
  output logic       vector_sel,
  output logic [9:0] ret_addr,
  output logic       in_service,
  output logic [3:0] missed_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ENTER,
    VECTOR,
    SERVICE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  // The drain counter is 4 bits wide, and the ROM address mux downstream is 10 bits wide.
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || $bits(VECTOR_ADDR) != 10) begin : g_bad_param
    $error("irq_sequencer: DRAIN_CYCLES must be 1..15");
  end

  state_t     state;
  logic [3:0] cnt;
  logic       s1, s2, s3;
  logic       rise;
  logic       pending;
  logic       entry_ok;

  assign rise     = s2 & ~s3;
  assign entry_ok = pending & i_flag & ~redirect_ex & ~hazard_stall;

  // Three-flop synchronizer on the asynchronous interrupt pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pending request and lost-edge counter; a new edge wins over the ENTER clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= 1'b0;
      missed_cnt <= '0;
    end else if (rise) begin
      pending <= 1'b1;
      if (pending && missed_cnt != 4'hF) begin
        missed_cnt <= missed_cnt + 4'd1;
      end
    end else if (state == ENTER) begin
      pending <= 1'b0;
    end
  end

  // Entry state machine with drain counter and return-address capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ret_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (entry_ok) begin
            state    <= DRAIN;
            cnt      <= CNT_INIT;
            ret_addr <= fetch_addr;
          end
        end
        DRAIN: begin
          if (cnt == 4'd0) begin
            state <= ENTER;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ENTER:   state <= VECTOR;
        VECTOR:  state <= SERVICE;
        SERVICE: begin
          if (reti_ex) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of control outputs from the current state
  always_comb begin
    fetch_hold = 1'b0;
    dec_nop    = 1'b0;
    int_dec    = 1'b0;
    vector_sel = 1'b0;
    in_service = 1'b0;
    case (state)
      DRAIN: begin
        fetch_hold = 1'b1;
        dec_nop    = 1'b1;
      end
      ENTER: begin
        fetch_hold = 1'b1;
        int_dec    = 1'b1;
      end
      VECTOR:  vector_sel = 1'b1;
      SERVICE: in_service = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: expected control vectors are queued as
// stimulus is applied and popped one per clock when the DUT is sampled.
module tb_irq_sequencer;

  logic       clk = 1'b0;
  logic       rst, rst_b;
  logic       irq_in, irq_b;
  logic       i_flag, redirect_ex, hazard_stall, reti_ex;
  logic [9:0] fetch_addr;

  logic       fh_a, dn_a, id_a, vs_a, is_a;
  logic [9:0] ret_a;
  logic [3:0] mc_a;
  logic       fh_b, dn_b, id_b, vs_b, is_b;
  logic [9:0] ret_b;
  logic [3:0] mc_b;

  logic [4:0] obs_a, obs_b;
  assign obs_a = {fh_a, dn_a, id_a, vs_a, is_a};
  assign obs_b = {fh_b, dn_b, id_b, vs_b, is_b};

  localparam logic [4:0] IDL = 5'b00000;
  localparam logic [4:0] DRN = 5'b11000;
  localparam logic [4:0] ENT = 5'b10100;
  localparam logic [4:0] VEC = 5'b00010;
  localparam logic [4:0] SRV = 5'b00001;

  always #5 clk = ~clk;

  irq_sequencer dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .i_flag(i_flag),
    .redirect_ex(redirect_ex), .hazard_stall(hazard_stall),
    .fetch_addr(fetch_addr), .reti_ex(reti_ex),
    .fetch_hold(fh_a), .dec_nop(dn_a), .int_dec(id_a), .vector_sel(vs_a),
    .ret_addr(ret_a), .in_service(is_a), .missed_cnt(mc_a)
  );

  irq_sequencer #(.DRAIN_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst_b), .irq_in(irq_b), .i_flag(i_flag),
    .redirect_ex(redirect_ex), .hazard_stall(hazard_stall),
    .fetch_addr(fetch_addr), .reti_ex(reti_ex),
    .fetch_hold(fh_b), .dec_nop(dn_b), .int_dec(id_b), .vector_sel(vs_b),
    .ret_addr(ret_b), .in_service(is_b), .missed_cnt(mc_b)
  );

  typedef struct {
    string      tag;
    bit         b;
    logic [4:0] v;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic push(input string tag, input logic [4:0] v, input int n, input bit b = 1'b0);
    for (int i = 0; i < n; i++) sb.push_back('{tag, b, v});
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    n_chk++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  // advance one clock, then compare the DUT against the next queued entry
  task automatic tick();
    exp_t       e;
    logic [4:0] o;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      o = e.b ? obs_b : obs_a;
      n_chk++;
      assert (o === e.v) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", e.tag, o, e.v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    irq_in = 1'b0; irq_b = 1'b0;
    i_flag = 1'b0; redirect_ex = 1'b0; hazard_stall = 1'b0; reti_ex = 1'b0;
    fetch_addr = 10'h000;
    #2;
    chk("reset_ctl_a", 32'(obs_a), 32'(IDL));
    chk("reset_ctl_b", 32'(obs_b), 32'(IDL));
    chk("reset_ret_a", 32'(ret_a), 0);
    chk("reset_missed_a", 32'(mc_a), 0);
    @(posedge clk); #1;
    rst = 1'b0; rst_b = 1'b0;
    tick(); tick();

    // basic entry
    i_flag = 1'b1; fetch_addr = 10'h012;
    push("basic_idle", IDL, 3);
    push("basic_drain", DRN, 2);
    push("basic_enter", ENT, 1);
    push("basic_vector", VEC, 1);
    push("basic_service", SRV, 2);
    irq_in = 1'b1;
    tick(); tick();
    chk("basic_pending_early", 32'(dut.pending), 0);
    tick();
    chk("basic_pending_k3", 32'(dut.pending), 1);
    irq_in = 1'b0;
    tick();
    fetch_addr = 10'h2AA;
    for (int i = 0; i < 5; i++) tick();
    chk("basic_ret_addr", 32'(ret_a), 32'h012);
    reti_ex = 1'b1;
    push("basic_reti", IDL, 3);
    tick();
    reti_ex = 1'b0;
    tick(); tick();

    // masked request waits for the I flag
    i_flag = 1'b0;
    push("masked_idle", IDL, 23);
    irq_in = 1'b1;
    for (int i = 0; i < 23; i++) begin
      tick();
      if (i == 1) irq_in = 1'b0;
    end
    chk("masked_pending", 32'(dut.pending), 1);
    i_flag = 1'b1;
    push("masked_drain", DRN, 2);
    push("masked_enter", ENT, 1);
    push("masked_vector", VEC, 1);
    push("masked_service", SRV, 1);
    for (int i = 0; i < 5; i++) tick();
    reti_ex = 1'b1;
    push("masked_reti", IDL, 1);
    tick();
    reti_ex = 1'b0;

    // entry blocked by redirect then stall; ret_addr from the entry cycle
    push("block_idle", IDL, 7);
    push("block_drain", DRN, 2);
    push("block_enter", ENT, 1);
    push("block_vector", VEC, 1);
    push("block_service", SRV, 1);
    irq_in = 1'b1; redirect_ex = 1'b1; fetch_addr = 10'h100;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) irq_in = 1'b0;
      fetch_addr = 10'h101 + 10'(i);
    end
    redirect_ex = 1'b0; hazard_stall = 1'b1;
    tick();
    hazard_stall = 1'b0; fetch_addr = 10'h155;
    tick();
    fetch_addr = 10'h3C3; reti_ex = 1'b1;
    tick();
    reti_ex = 1'b0;
    tick(); tick(); tick();
    chk("block_ret_addr", 32'(ret_a), 32'h155);

    // overrun: 18 edges while in service
    push("overrun_service", SRV, 75);
    for (int e = 0; e < 18; e++) begin
      irq_in = 1'b1;
      tick(); tick();
      irq_in = 1'b0;
      tick(); tick();
      if (e == 9) chk("overrun_missed_mid", 32'(mc_a), 9);
    end
    tick(); tick(); tick();
    chk("overrun_pending", 32'(dut.pending), 1);
    chk("overrun_missed_sat", 32'(mc_a), 15);
    reti_ex = 1'b1;
    push("overrun_reti", IDL, 1);
    push("overrun_drain", DRN, 2);
    push("overrun_enter", ENT, 1);
    push("overrun_vector", VEC, 1);
    push("overrun_service", SRV, 1);
    tick();
    reti_ex = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("overrun_ret_addr", 32'(ret_a), 32'h3C3);

    // edge coincident with ENTER keeps pending set
    reti_ex = 1'b1;
    push("coin_reti", IDL, 1);
    tick();
    reti_ex = 1'b0;
    push("coin_idle", IDL, 3);
    push("coin_drain", DRN, 2);
    push("coin_enter", ENT, 1);
    push("coin_vector", VEC, 1);
    push("coin_service", SRV, 1);
    push("coin_reti2", IDL, 1);
    push("coin_drain2", DRN, 2);
    push("coin_enter2", ENT, 1);
    push("coin_vector2", VEC, 1);
    push("coin_service2", SRV, 1);
    irq_in = 1'b1;
    tick(); tick();
    irq_in = 1'b0;
    tick(); tick();
    irq_in = 1'b1;
    tick(); tick();
    irq_in = 1'b0;
    tick();
    chk("coin_pending", 32'(dut.pending), 1);
    tick();
    reti_ex = 1'b1;
    tick();
    reti_ex = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("coin_pending_clear", 32'(dut.pending), 0);
    reti_ex = 1'b1;
    push("coin_done", IDL, 3);
    tick();
    reti_ex = 1'b0;
    tick(); tick();

    // DRAIN_CYCLES = 4 instance: full entry timing
    fetch_addr = 10'h0AB;
    push("b_idle", IDL, 3, 1'b1);
    push("b_drain", DRN, 4, 1'b1);
    push("b_enter", ENT, 1, 1'b1);
    push("b_vector", VEC, 1, 1'b1);
    push("b_service", SRV, 1, 1'b1);
    irq_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 1) irq_b = 1'b0;
    end
    chk("b_ret_addr", 32'(ret_b), 32'h0AB);
    reti_ex = 1'b1;
    push("b_reti", IDL, 1, 1'b1);
    tick();
    reti_ex = 1'b0;

    // async reset in DRAIN with a missed edge recorded
    fetch_addr = 10'h2F0;
    push("b2_idle", IDL, 3, 1'b1);
    push("b2_drain", DRN, 4, 1'b1);
    irq_b = 1'b1;
    tick(); tick();
    irq_b = 1'b0;
    tick(); tick();
    irq_b = 1'b1;
    tick(); tick();
    irq_b = 1'b0;
    tick();
    chk("b2_missed_pre", 32'(mc_b), 1);
    chk("b2_ret_pre", 32'(ret_b), 32'h2F0);
    #3;
    rst_b = 1'b1;
    #1;
    chk("b2_rst_ctl", 32'(obs_b), 32'(IDL));
    chk("b2_rst_ret", 32'(ret_b), 0);
    chk("b2_rst_missed", 32'(mc_b), 0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    push("b2_lost", IDL, 6, 1'b1);
    for (int i = 0; i < 6; i++) tick();

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
